// File: rtl/mul_bcd_arbiter.sv
// Round-robin arbiter that shares one multiply/BCD engine among NREQ requesters.
// Each granted request is issued to the engine, waited on with a timeout, then returned as a response.
module mul_bcd_arbiter #(
  parameter int N       = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  output logic                     eng_start,
  output logic [N-1:0]             eng_a,
  output logic [N-1:0]             eng_b,
  input  logic                     eng_done,
  input  logic [2*N-1:0]           eng_product,
  input  logic [15:0]              eng_bcd,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [2*N-1:0]           rsp_product,
  output logic [15:0]              rsp_bcd,
  output logic                     rsp_timeout,
  output logic                     busy
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] cur_id;
  logic [7:0]      timer;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] idx;
  logic [N-1:0]    sel_a;
  logic [N-1:0]    sel_b;

  // Search starts one past the last served requester and wraps, so every requester gets a turn.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = last;
    sel_a       = '0;
    sel_b       = '0;
    req_ready   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (idx == ID_W'(NREQ-1)) ? '0 : idx + ID_W'(1);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        sel_a = req_a[k*N +: N];
        sel_b = req_b[k*N +: N];
      end
    end
    if (state == IDLE && !reset) begin
      req_ready[grant_idx] = grant_found;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= ID_W'(NREQ-1);
      cur_id      <= '0;
      timer       <= '0;
      eng_start   <= 1'b0;
      eng_a       <= '0;
      eng_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_bcd     <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          timer <= '0;
          if (grant_found) begin
            eng_a     <= sel_a;
            eng_b     <= sel_b;
            cur_id    <= grant_idx;
            eng_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          eng_start <= 1'b0;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // A completion on the final allowed cycle still counts as a normal result.
          if (eng_done) begin
            rsp_product <= eng_product;
            rsp_bcd     <= eng_bcd;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            eng_a       <= '0;
            eng_b       <= '0;
            state       <= RESP;
          end else if (timer == 8'(TIMEOUT-1)) begin
            rsp_product <= '0;
            rsp_bcd     <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            eng_a       <= '0;
            eng_b       <= '0;
            state       <= RESP;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last      <= rsp_id;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_bcd_arbiter.md
MUL_BCD_ARBITER -- requirements
Module: mul_bcd_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 8, operand width in bits.
REQ-002 The block SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 40, maximum WAIT cycles before abort (1..255).
REQ-004 The block SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid  in  NREQ  per-requester request.
REQ-007 The block SHALL have port req_ready  out  NREQ  per-requester accept.
REQ-008 The block SHALL have port req_a  in  NREQ*N  operand A; requester i in bits [i*N +: N].
REQ-009 The block SHALL have port req_b  in  NREQ*N  operand B; same packing as req_a.
REQ-010 The block SHALL have port eng_start  out  1  start pulse to the shared multiply/BCD engine.
REQ-011 The block SHALL have ports eng_a, eng_b  out  N  operands to the engine.
REQ-012 The block SHALL have port eng_done  in  1  engine completion pulse.
REQ-013 The block SHALL have port eng_product  in  2N  engine binary product, valid with eng_done.
REQ-014 The block SHALL have port eng_bcd  in  16  engine BCD digits {thousands, hundreds, tens, units}, valid with eng_done.
REQ-015 The block SHALL have port rsp_valid  out  1  response valid.
REQ-016 The block SHALL have port rsp_ready  in  1  response accept.
REQ-017 The block SHALL have port rsp_id  out  ceil(log2 NREQ)  index of the served requester.
REQ-018 The block SHALL have ports rsp_product  out  2N, rsp_bcd  out  16  captured results.
REQ-019 The block SHALL have port rsp_timeout  out  1  response is an abort.
REQ-020 The block SHALL have port busy  out  1  high whenever state is not IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: with any req_valid bit set, the block SHALL select winner g round-robin, searching from (last+1) mod NREQ upward with wrap, and SHALL assert req_ready[g] combinationally in that cycle; it SHALL then latch req_a/req_b slice g and g, and go to ISSUE.
REQ-023 req_ready SHALL be one-hot or zero, and nonzero only in IDLE.
REQ-024 ISSUE: eng_start SHALL be high for exactly this one cycle, then go to WAIT with the timer cleared.
REQ-025 eng_a/eng_b SHALL present the latched operands from ISSUE through WAIT, and SHALL be 0 otherwise.
REQ-026 WAIT: on eng_done, the block SHALL capture eng_product/eng_bcd, set rsp_timeout=0, and go to RESP; rsp_valid SHALL rise the cycle after eng_done is sampled.
REQ-027 WAIT: the timer SHALL increment each cycle; when it reaches TIMEOUT without eng_done, the block SHALL go to RESP with rsp_product=0, rsp_bcd=0, rsp_timeout=1.
REQ-028 If eng_done and timer expiry coincide, done SHALL take priority (normal response).
REQ-029 eng_done outside WAIT SHALL be ignored.
REQ-030 RESP: rsp_valid=1 with all rsp_* held stable until rsp_ready; on handshake the block SHALL set last=g and return to IDLE; the earliest next grant is the following cycle.
REQ-031 Requester inputs SHALL be sampled only at their handshake; later changes to req_valid/req_a/req_b SHALL NOT affect the operation in flight.
REQ-032 Minimum request-to-response latency SHALL be grant cycle T, eng_start T+1, rsp_valid one cycle after eng_done.

Reset
REQ-033 On reset the block SHALL force state=IDLE, last=NREQ-1 (requester 0 served first), timer=0, and all outputs to 0.
REQ-034 Reset mid-operation SHALL abandon the operation with no response; a stale eng_done after reset SHALL be ignored per REQ-029.

Verification
REQ-035 Req 1 only, A=12, B=34; engine returns 408/0x0408 15 cycles after start -> eng_a=12, eng_b=34, one-cycle eng_start, rsp_id=1, rsp_product=408, rsp_bcd=0x0408, rsp_timeout=0.
REQ-036 All four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1; never two req_ready bits high.
REQ-037 Engine never pulses eng_done -> rsp_valid rises TIMEOUT cycles after WAIT entry with rsp_timeout=1, product 0, bcd 0.
REQ-038 rsp_ready low 5 cycles in RESP with other requests pending -> rsp_* stable, req_ready=0 throughout.
REQ-039 Reset asserted in WAIT, eng_done pulsed 3 cycles after release -> no rsp_valid, all outputs 0, next grant goes to requester 0.
REQ-040 eng_done on the exact expiry cycle -> normal response, rsp_timeout=0.
